// File: rtl/int_ack_decoder.sv
// int_ack_decoder
//   CPU-side responder for a 4-source interrupt prioritizer. Accepts the
//   winning code and emits a one-hot acknowledge pulse ACK_CYCLES clocks wide.
//   It also presents an interrupt vector and tracks the in-service sources
//   until the CPU strobes end-of-interrupt.
//
//   Optional feature macro: INT_NEST_EN
//     defined   - a strictly higher-priority request is accepted while in
//                 SERVICE (nesting); in_service may hold several bits.
//     undefined - req is ignored in SERVICE; in_service is at most one-hot.
//
// Parameters
//   VEC_BASE    base of vector table; vec = VEC_BASE + code*4 (mod 256)
//   ACK_CYCLES  ack pulse width in clocks, 1..15
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req        in   prioritizer has a pending request
//   code[1:0]  in   winning source index (3 = highest priority)
//   cpu_ready  in   CPU can accept an interrupt this cycle
//   eoi        in   end-of-interrupt strobe, one cycle
//   ack[3:0]   out  one-hot acknowledge to sources a..d
//   vec_valid  out  vec is valid
//   vec[7:0]   out  interrupt vector (holds last value when not valid)
//   in_service out  sources currently being serviced
//   busy       out  state is not IDLE
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for req && cpu_ready
// ACK     | driving ack/vec for ACK_CYCLES clocks for the latched code
// SERVICE | waiting for eoi (or, with nesting, a higher request)

module int_ack_decoder #(
    parameter logic [7:0]  VEC_BASE   = 8'h20,
    parameter int unsigned ACK_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic [1:0] code,
    input  logic       cpu_ready,
    input  logic       eoi,
    output logic [3:0] ack,
    output logic       vec_valid,
    output logic [7:0] vec,
    output logic [3:0] in_service,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACK     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(ACK_CYCLES);

    state_t     state, state_nxt;
    logic [1:0] cur, cur_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [3:0] ack_nxt;
    logic       vec_valid_nxt;
    logic [7:0] vec_nxt;
    logic [3:0] in_service_nxt;
    logic       busy_nxt;
    logic       accept;
    logic [3:0] in_service_cleared;

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        onehot = 4'b0001 << idx;
    endfunction

    // Drop the highest-priority bit: the most recently nested source is
    // always the highest one still set.
    function automatic logic [3:0] clr_top(input logic [3:0] v);
        logic [3:0] r;
        r = v;
        if (v[3])      r[3] = 1'b0;
        else if (v[2]) r[2] = 1'b0;
        else if (v[1]) r[1] = 1'b0;
        else           r[0] = 1'b0;
        return r;
    endfunction

`ifdef INT_NEST_EN
    function automatic logic [1:0] top_idx(input logic [3:0] v);
        if (v[3])      return 2'd3;
        else if (v[2]) return 2'd2;
        else if (v[1]) return 2'd1;
        else           return 2'd0;
    endfunction
`endif

    assign in_service_cleared = clr_top(in_service);

    always_comb begin
        state_nxt      = state;
        cur_nxt        = cur;
        cnt_nxt        = cnt;
        ack_nxt        = ack;
        vec_valid_nxt  = vec_valid;
        vec_nxt        = vec;
        in_service_nxt = in_service;
        accept         = 1'b0;

        case (state)
            IDLE: begin
                if (req && cpu_ready)
                    accept = 1'b1;
            end
            ACK: begin
                // cnt counts the ack cycles still to be shown including this one
                if (cnt <= 4'd1) begin
                    state_nxt      = SERVICE;
                    ack_nxt        = 4'b0000;
                    vec_valid_nxt  = 1'b0;
                    in_service_nxt = in_service | onehot(cur);
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            SERVICE: begin
                // eoi has precedence over any request on the same edge
                if (eoi) begin
                    in_service_nxt = in_service_cleared;
                    if (in_service_cleared == 4'b0000)
                        state_nxt = IDLE;
                end
`ifdef INT_NEST_EN
                else if (req && cpu_ready && (code > top_idx(in_service))) begin
                    accept = 1'b1;
                end
`endif
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (accept) begin
            state_nxt     = ACK;
            cur_nxt       = code;
            cnt_nxt       = CNT_INIT;
            ack_nxt       = onehot(code);
            vec_valid_nxt = 1'b1;
            vec_nxt       = VEC_BASE + {4'b0000, code, 2'b00};
        end

        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cur        <= 2'd0;
            cnt        <= 4'd0;
            ack        <= 4'b0000;
            vec_valid  <= 1'b0;
            vec        <= 8'h00;
            in_service <= 4'b0000;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            cur        <= cur_nxt;
            cnt        <= cnt_nxt;
            ack        <= ack_nxt;
            vec_valid  <= vec_valid_nxt;
            vec        <= vec_nxt;
            in_service <= in_service_nxt;
            busy       <= busy_nxt;
        end
    end

endmodule
